// File: rtl/mips_mem_pkg.sv
// Shared types and default sizes for the pipe_MIPS32 unified memory arbiter.
package mips_mem_pkg;

    localparam int AW_DEF       = 10;
    localparam int DW_DEF       = 32;
    localparam int MAX_WAIT_DEF = 4;

    // Bit positions inside the one-hot grant vector
    localparam int G_IF   = 0;
    localparam int G_DATA = 1;
    localparam int G_DBG  = 2;

    // Which requester is waiting for read data next cycle
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DATA,
        OWN_DBG
    } owner_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } arb_state_t;

endpackage

// File: rtl/mips_arb_prio.sv
// Combinational winner select: dbg always first; while halted nobody else is
// eligible; otherwise data beats IF unless IF has been starved long enough.
module mips_arb_prio
    import mips_mem_pkg::*;
(
    input  logic       i_dbg_req,
    input  logic       i_d_req,
    input  logic       i_if_req,
    input  logic       i_starve,
    input  logic       i_halted,
    output logic [2:0] o_gnt
);

    // One-hot grant from the request set
    always_comb begin
        // NOTE: default every output before the if-chain so no path leaves it unassigned (no latch).
        o_gnt = '0;
        if (i_dbg_req) begin
            o_gnt[G_DBG] = 1'b1;
        end else if (!i_halted) begin
            if (i_starve && i_if_req) begin
                o_gnt[G_IF] = 1'b1;
            end else if (i_d_req) begin
                o_gnt[G_DATA] = 1'b1;
            end else if (i_if_req) begin
                o_gnt[G_IF] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-ported Mem arbiter for IF, MEM-stage data and the debug/loader port.
// Grants are combinational; read data returns one cycle after the grant to
// whichever requester the registered owner tag names.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          halt_in,
    input  logic          resume_in,
    output logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t    r_state;
    owner_t        r_owner;
    logic [WW-1:0] r_if_wait;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic [2:0]    w_gnt;
    logic          w_halted;
    logic          w_starve;
    owner_t        w_owner_nxt;

    assign w_halted = (r_state == ST_HALTED);
    assign w_starve = (r_if_wait == WW'(MAX_WAIT));

    mips_arb_prio u_prio (
        .i_dbg_req (dbg_req),
        .i_d_req   (d_req),
        .i_if_req  (if_req),
        .i_starve  (w_starve),
        .i_halted  (w_halted),
        .o_gnt     (w_gnt)
    );

    assign if_gnt  = w_gnt[G_IF];
    assign d_gnt   = w_gnt[G_DATA];
    assign dbg_gnt = w_gnt[G_DBG];
    assign halted  = w_halted;

    // Steer the winner onto the memory command and pick the read owner tag
    always_comb begin
        mem_en      = |w_gnt;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_owner_nxt = OWN_NONE;
        if (w_gnt[G_DBG]) begin
            mem_we      = dbg_we;
            mem_addr    = dbg_addr;
            mem_wdata   = dbg_wdata;
            w_owner_nxt = dbg_we ? OWN_NONE : OWN_DBG;
        end else if (w_gnt[G_DATA]) begin
            mem_we      = d_we;
            mem_addr    = d_addr;
            mem_wdata   = d_wdata;
            w_owner_nxt = d_we ? OWN_NONE : OWN_DATA;
        end else if (w_gnt[G_IF]) begin
            mem_addr    = if_addr;
            w_owner_nxt = OWN_IF;
        end
    end

    // RUN/HALTED state; halt wins when both pulses arrive together
    always_ff @(posedge clk1 or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_HALTED;
        end else if (halt_in) begin
            r_state <= ST_HALTED;
        end else if (resume_in) begin
            r_state <= ST_RUN;
        end
    end

    // IF starvation counter: counts denied IF cycles, saturates, held at 0 while halted
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_if_wait <= '0;
        end else if (w_halted || halt_in || !if_req || w_gnt[G_IF]) begin
            r_if_wait <= '0;
        end else if (!w_starve) begin
            r_if_wait <= r_if_wait + 1'b1;
        end
    end

    // Owner tag of the read issued this cycle
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Keep the last returned word for each port so idle rdata holds steady
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (r_owner == OWN_IF)   r_if_rdata  <= mem_rdata;
            if (r_owner == OWN_DATA) r_d_rdata   <= mem_rdata;
            if (r_owner == OWN_DBG)  r_dbg_rdata <= mem_rdata;
        end
    end

    assign if_rvalid  = (r_owner == OWN_IF);
    assign d_rvalid   = (r_owner == OWN_DATA);
    assign dbg_rvalid = (r_owner == OWN_DBG);
    assign if_rdata   = if_rvalid  ? mem_rdata : r_if_rdata;
    assign d_rdata    = d_rvalid   ? mem_rdata : r_d_rdata;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mips_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clk1 = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we, dbg_req, dbg_we, halt_in, resume_in;
    logic [AW-1:0] if_addr, d_addr, dbg_addr;
    logic [DW-1:0] d_wdata, dbg_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, dbg_gnt, dbg_rvalid, halted;
    logic [DW-1:0] if_rdata, d_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk1(clk1), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .halt_in(halt_in), .resume_in(resume_in), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    // Environment: the Mem array itself, synchronous read with one-cycle latency
    logic [DW-1:0] ram [1024];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Behavioural model state (requester codes: 0 none, 1 IF, 2 data, 3 dbg)
    logic [DW-1:0] m_mem [1024];
    bit            m_halted;
    int            m_wait;
    int            m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_last [1:3];

    // Values captured at the last compare
    logic          c_if_gnt, c_d_gnt, c_dbg_gnt, c_halted;
    logic          c_if_rvalid, c_d_rvalid, c_dbg_rvalid;
    logic [DW-1:0] c_if_rdata, c_d_rdata, c_dbg_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b1;
        m_wait   = 0;
        m_pend   = 0;
        for (int k = 1; k <= 3; k++) m_last[k] = '0;
    endtask

    // Compare the DUT against the model for the current cycle, then advance the model
    task automatic compare_and_update();
        int            eg;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rd [1:3];

        c_if_gnt = if_gnt; c_d_gnt = d_gnt; c_dbg_gnt = dbg_gnt; c_halted = halted;
        c_if_rvalid = if_rvalid; c_d_rvalid = d_rvalid; c_dbg_rvalid = dbg_rvalid;
        c_if_rdata = if_rdata; c_d_rdata = d_rdata; c_dbg_rdata = dbg_rdata;

        // Read response from the previous cycle's read, others hold
        for (int k = 1; k <= 3; k++) e_rd[k] = (m_pend == k) ? m_pend_data : m_last[k];
        check("if_rvalid",  32'(if_rvalid),  32'(m_pend == 1));
        check("d_rvalid",   32'(d_rvalid),   32'(m_pend == 2));
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend == 3));
        check("if_rdata",   if_rdata,  e_rd[1]);
        check("d_rdata",    d_rdata,   e_rd[2]);
        check("dbg_rdata",  dbg_rdata, e_rd[3]);
        check("halted",     32'(halted), 32'(m_halted));
        for (int k = 1; k <= 3; k++) m_last[k] = e_rd[k];

        // Who should win this cycle
        eg = 0;
        if (dbg_req) eg = 3;
        else if (!m_halted) begin
            if (if_req && m_wait >= MAX_WAIT) eg = 1;
            else if (d_req)                   eg = 2;
            else if (if_req)                  eg = 1;
        end
        check("if_gnt",  32'(if_gnt),  32'(eg == 1));
        check("d_gnt",   32'(d_gnt),   32'(eg == 2));
        check("dbg_gnt", 32'(dbg_gnt), 32'(eg == 3));
        check("mem_en",  32'(mem_en),  32'(eg != 0));

        e_we = 1'b0; e_addr = '0; e_wdata = '0;
        case (eg)
            1: begin e_addr = if_addr; end
            2: begin e_we = d_we;   e_addr = d_addr;   e_wdata = d_wdata;   end
            3: begin e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; end
            default: ;
        endcase
        check("mem_we", 32'(mem_we), 32'(e_we));
        if (eg != 0) begin
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        end

        // Advance the model
        if (eg != 0 && e_we) m_mem[e_addr] = e_wdata;
        m_pend      = (eg != 0 && !e_we) ? eg : 0;
        m_pend_data = m_mem[e_addr];
        if (m_halted || halt_in || !if_req || eg == 1) m_wait = 0;
        else m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        if (halt_in)        m_halted = 1'b1;
        else if (resume_in) m_halted = 1'b0;
    endtask

    task automatic step();
        @(negedge clk1);
        compare_and_update();
        @(posedge clk1);
        #1;
    endtask

    task automatic rand_stim();
        if (!if_req || c_if_gnt) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = AW'($urandom_range(0, 15));
        end
        if (!d_req || c_d_gnt) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = AW'($urandom_range(0, 15));
            d_wdata = $urandom;
        end
        if (!dbg_req || c_dbg_gnt) begin
            dbg_req   = m_halted ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = AW'($urandom_range(0, 15));
            dbg_wdata = $urandom;
        end
        halt_in   = 1'b0;
        resume_in = 1'b0;
        if (!m_halted) halt_in = ($urandom_range(0, 63) == 0);
        else           resume_in = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 127) == 0) begin
            halt_in   = 1'b1;
            resume_in = 1'b1;
        end
    endtask

    logic [7:0] got_d, got_i;

    initial begin
        for (int a = 0; a < 1024; a++) begin
            ram[a]   = '0;
            m_mem[a] = '0;
        end
        mem_rdata = '0;
        reset = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; dbg_req = 0; dbg_we = 0; halt_in = 0; resume_in = 0;
        if_addr = '0; d_addr = '0; dbg_addr = '0; d_wdata = '0; dbg_wdata = '0;
        model_reset();

        // Reset state
        #1;
        check("rst_halted",     32'(halted), 32'd1);
        check("rst_gnt",        32'({if_gnt, d_gnt, dbg_gnt}), 32'd0);
        check("rst_rvalid",     32'({if_rvalid, d_rvalid, dbg_rvalid}), 32'd0);
        check("rst_mem_en",     32'(mem_en), 32'd0);
        check("rst_mem_we",     32'(mem_we), 32'd0);
        check("rst_if_rdata",   if_rdata,  32'd0);
        check("rst_d_rdata",    d_rdata,   32'd0);
        check("rst_dbg_rdata",  dbg_rdata, 32'd0);
        @(posedge clk1);
        #1;
        reset = 1'b0;

        // Program load and readback while halted; IF is never served
        if_req = 1; if_addr = '0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd0; dbg_wdata = 32'h28010078;
        step();
        check("load0_gnt", 32'(c_dbg_gnt), 32'd1);
        dbg_addr = 10'd120; dbg_wdata = 32'd85;
        step();
        check("load120_gnt", 32'(c_dbg_gnt), 32'd1);
        check("load_if_blocked", 32'(c_if_gnt), 32'd0);
        dbg_we = 0;
        step();
        check("read120_gnt", 32'(c_dbg_gnt), 32'd1);
        dbg_req = 0;
        step();
        check("read120_rvalid", 32'(c_dbg_rvalid), 32'd1);
        check("read120_rdata",  c_dbg_rdata, 32'd85);
        check("read120_halted", 32'(c_halted), 32'd1);
        check("read120_if_blocked", 32'(c_if_gnt), 32'd0);

        // Resume: IF fetches Mem[0] in the following cycle
        resume_in = 1;
        step();
        check("resume_no_gnt", 32'(c_if_gnt), 32'd0);
        resume_in = 0;
        step();
        check("resume_if_gnt", 32'(c_if_gnt), 32'd1);
        check("resume_halted", 32'(c_halted), 32'd0);
        step();
        check("fetch_rvalid", 32'(c_if_rvalid), 32'd1);
        check("fetch_rdata",  c_if_rdata, 32'h28010078);
        if_req = 0;
        step();

        // Contention: data and IF held high, IF promoted after MAX_WAIT denials
        d_req = 1; d_we = 0; d_addr = 10'd5; if_req = 1; if_addr = 10'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            got_d[i] = c_d_gnt;
            got_i[i] = c_if_gnt;
            if (i == 4) check("wait_cleared", 32'(dut.r_if_wait), 32'd0);
        end
        check("contend_d_pattern",  32'(got_d), 32'hEF);
        check("contend_if_pattern", 32'(got_i), 32'h10);
        step();
        check("wait_saturated", 32'(dut.r_if_wait), 32'(MAX_WAIT));

        // Debug preempts even a starved IF
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd120;
        step();
        check("preempt_dbg", 32'({c_dbg_gnt, c_d_gnt, c_if_gnt}), 32'b100);
        dbg_req = 0; if_req = 0;
        step();
        check("preempt_rdata", c_dbg_rdata, 32'd85);

        // Halt edge: read granted with halt_in still returns data
        d_req = 1; d_we = 0; d_addr = 10'd121; halt_in = 1;
        step();
        check("halt_edge_gnt", 32'(c_d_gnt), 32'd1);
        halt_in = 0;
        step();
        check("halt_edge_rvalid", 32'(c_d_rvalid), 32'd1);
        check("halt_edge_halted", 32'(c_halted), 32'd1);
        check("halt_edge_no_gnt", 32'(c_d_gnt), 32'd0);
        step();
        check("halted_d_blocked", 32'(c_d_gnt), 32'd0);
        halt_in = 1; resume_in = 1;
        step();
        halt_in = 0; resume_in = 0;
        step();
        check("halt_beats_resume", 32'(c_halted), 32'd1);
        resume_in = 1; d_req = 0;
        step();
        resume_in = 1; halt_in = 1; d_req = 0;
        step();
        resume_in = 0; halt_in = 0;
        step();
        check("halt_beats_resume_run", 32'(c_halted), 32'd1);

        // Reset in the cycle after a data read grant drops the response
        resume_in = 1;
        step();
        resume_in = 0; d_req = 1; d_we = 0; d_addr = 10'd121;
        step();
        check("prereset_d_gnt", 32'(c_d_gnt), 32'd1);
        d_req = 0;
        reset = 1;
        #1;
        check("midread_rvalid", 32'(d_rvalid), 32'd0);
        check("midread_mem_en", 32'(mem_en), 32'd0);
        check("midread_halted", 32'(halted), 32'd1);
        model_reset();
        @(posedge clk1);
        #1;
        reset = 0;

        // Randomized traffic
        c_if_gnt = 0; c_d_gnt = 0; c_dbg_gnt = 0;
        resume_in = 1;
        step();
        resume_in = 0;
        for (int n = 0; n < 4000; n++) begin
            rand_stim();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
